// File: rtl/cache_arb_pkg.sv
// Shared types and default widths for the two-port cache arbiter.
package cache_arb_pkg;

  localparam int unsigned ADDR_W   = 27;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned TAG_W    = 13;
  localparam int unsigned INDEX_W  = 10;
  localparam int unsigned OFFSET_W = 4;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_t;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  typedef struct packed {
    logic                pending;
    op_t                 op;
    logic [ADDR_W-1:0]   addr;
    logic [DATA_W-1:0]   data;
  } slot_t;

endpackage

// File: rtl/cache_arb_slot.sv
// One requester's pending slot: captures a request pulse when idle,
// drops pulses while busy, and prefers the write when both enables fire.
module cache_arb_slot
  import cache_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = cache_arb_pkg::ADDR_W,
  parameter int unsigned DATA_W = cache_arb_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_en,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              in_flight,
  input  logic              clear,
  output logic              pending,
  output op_t               op,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data,
  output logic              busy
);

  assign busy = pending | in_flight;

  // Capture a new request only while the slot is free; clear on completion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= 1'b0;
      op      <= OP_RD;
      addr    <= '0;
      data    <= '0;
    end else if (clear) begin
      pending <= 1'b0;
    end else if (!busy && wr_en) begin
      pending <= 1'b1;
      op      <= OP_WR;
      addr    <= wr_addr;
      data    <= wr_data;
    end else if (!busy && rd_en) begin
      pending <= 1'b1;
      op      <= OP_RD;
      addr    <= rd_addr;
    end
  end

endmodule

// File: rtl/cache_port_arbiter.sv
// Two-requester arbiter for the single cache core port.
// Build option: CACHE_ARB_RR_EN selects round-robin arbitration; when
// undefined requester 0 has fixed priority.
module cache_port_arbiter
  import cache_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = cache_arb_pkg::ADDR_W,
  parameter int unsigned DATA_W = cache_arb_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rq0_rd_en,
  input  logic              rq0_wr_en,
  input  logic [ADDR_W-1:0] rq0_rd_addr,
  input  logic [ADDR_W-1:0] rq0_wr_addr,
  input  logic [DATA_W-1:0] rq0_wr_data,
  output logic              rq0_rd_fin,
  output logic              rq0_wr_fin,
  output logic [DATA_W-1:0] rq0_rd_data,
  output logic              rq0_busy,
  input  logic              rq1_rd_en,
  input  logic              rq1_wr_en,
  input  logic [ADDR_W-1:0] rq1_rd_addr,
  input  logic [ADDR_W-1:0] rq1_wr_addr,
  input  logic [DATA_W-1:0] rq1_wr_data,
  output logic              rq1_rd_fin,
  output logic              rq1_wr_fin,
  output logic [DATA_W-1:0] rq1_rd_data,
  output logic              rq1_busy,
  output logic              core2cache_rd_en,
  output logic              core2cache_wr_en,
  output logic [ADDR_W-1:0] core2cache_rd_addr,
  output logic [ADDR_W-1:0] core2cache_wr_addr,
  output logic [DATA_W-1:0] core2cache_wr_data,
  input  logic              cache2core_rd_fin,
  input  logic              cache2core_wr_fin,
  input  logic [DATA_W-1:0] cache2core_rd_data
);

  state_t            state;
  logic              grant;
  op_t               grant_op;
  logic              last_grant;

  logic              pend0, pend1;
  op_t               op0, op1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] data0, data1;

  logic              win;
  op_t               win_op;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_data;
  logic              fin_ok;

  cache_arb_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_slot0 (
    .clk       (clk),
    .rst       (rst),
    .rd_en     (rq0_rd_en),
    .wr_en     (rq0_wr_en),
    .rd_addr   (rq0_rd_addr),
    .wr_addr   (rq0_wr_addr),
    .wr_data   (rq0_wr_data),
    .in_flight (state == S_WAIT && grant == 1'b0),
    .clear     (fin_ok && grant == 1'b0),
    .pending   (pend0),
    .op        (op0),
    .addr      (addr0),
    .data      (data0),
    .busy      (rq0_busy)
  );

  cache_arb_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_slot1 (
    .clk       (clk),
    .rst       (rst),
    .rd_en     (rq1_rd_en),
    .wr_en     (rq1_wr_en),
    .rd_addr   (rq1_rd_addr),
    .wr_addr   (rq1_wr_addr),
    .wr_data   (rq1_wr_data),
    .in_flight (state == S_WAIT && grant == 1'b1),
    .clear     (fin_ok && grant == 1'b1),
    .pending   (pend1),
    .op        (op1),
    .addr      (addr1),
    .data      (data1),
    .busy      (rq1_busy)
  );

  // Winner selection, grant mux and acceptance of the matching cache fin.
  always_comb begin
    win = 1'b0;
`ifdef CACHE_ARB_RR_EN
    if (pend0 && pend1) win = ~last_grant;
    else                win = pend1 & ~pend0;
`else
    // With nothing pending the winner is irrelevant; last_grant is just a
    // stable default there.
    if (pend0)      win = 1'b0;
    else if (pend1) win = 1'b1;
    else            win = last_grant;
`endif
    win_op   = win ? op1   : op0;
    win_addr = win ? addr1 : addr0;
    win_data = win ? data1 : data0;
    fin_ok   = (state == S_WAIT) &&
               ((grant_op == OP_WR) ? cache2core_wr_fin : cache2core_rd_fin);
  end

  // Issue/wait FSM with registered cache-side pulses and return demux.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state              <= S_IDLE;
      grant              <= 1'b0;
      grant_op           <= OP_RD;
      last_grant         <= 1'b1;
      core2cache_rd_en   <= 1'b0;
      core2cache_wr_en   <= 1'b0;
      core2cache_rd_addr <= '0;
      core2cache_wr_addr <= '0;
      core2cache_wr_data <= '0;
      rq0_rd_fin         <= 1'b0;
      rq0_wr_fin         <= 1'b0;
      rq1_rd_fin         <= 1'b0;
      rq1_wr_fin         <= 1'b0;
      rq0_rd_data        <= '0;
      rq1_rd_data        <= '0;
    end else begin
      core2cache_rd_en <= 1'b0;
      core2cache_wr_en <= 1'b0;
      rq0_rd_fin       <= 1'b0;
      rq0_wr_fin       <= 1'b0;
      rq1_rd_fin       <= 1'b0;
      rq1_wr_fin       <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (pend0 || pend1) begin
            grant      <= win;
            last_grant <= win;
            grant_op   <= win_op;
            if (win_op == OP_WR) begin
              core2cache_wr_en   <= 1'b1;
              core2cache_wr_addr <= win_addr;
              core2cache_wr_data <= win_data;
            end else begin
              core2cache_rd_en   <= 1'b1;
              core2cache_rd_addr <= win_addr;
            end
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (fin_ok) begin
            state <= S_IDLE;
            if (grant) begin
              if (grant_op == OP_WR) begin
                rq1_wr_fin <= 1'b1;
              end else begin
                rq1_rd_fin  <= 1'b1;
                rq1_rd_data <= cache2core_rd_data;
              end
            end else begin
              if (grant_op == OP_WR) begin
                rq0_wr_fin <= 1'b1;
              end else begin
                rq0_rd_fin  <= 1'b1;
                rq0_rd_data <= cache2core_rd_data;
              end
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
